// File: rtl/mem_access_pkg.sv
// Shared opcodes, FSM state type and opcode classification helpers for the
// memory-access pipeline stage.
package mem_pkg;

   localparam logic [5:0] OP_ALU_LAST = 6'h0B;
   localparam logic [5:0] OP_LDW      = 6'h0C;
   localparam logic [5:0] OP_STW      = 6'h0D;
   localparam logic [5:0] OP_BZ       = 6'h0E;
   localparam logic [5:0] OP_BEQ      = 6'h0F;
   localparam logic [5:0] OP_JR       = 6'h10;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      WAIT = 2'd2
   } mem_state_t;

   function automatic logic is_alu_op(input logic [5:0] op);
      return (op <= OP_ALU_LAST);
   endfunction

   function automatic logic is_branch_op(input logic [5:0] op);
      return (op == OP_BZ) || (op == OP_BEQ) || (op == OP_JR);
   endfunction

endpackage

// File: rtl/mem_access_if.sv
// Execute-side, data-memory and writeback signals of the memory-access stage.
// The stage itself uses the master modport; its environment uses slave.
interface mem_access_if;

   logic        ex_valid;
   logic        ex_ready;
   logic [5:0]  ex_op;
   logic [31:0] ex_result;
   logic [31:0] ex_addr;
   logic [31:0] ex_wdata;
   logic [4:0]  ex_dest;
   logic        mem_req;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic        mem_gnt;
   logic        mem_rvalid;
   logic [31:0] mem_rdata;
   logic        wb_valid;
   logic        wb_we;
   logic [4:0]  wb_dest;
   logic [31:0] wb_data;
   logic        mem_err;

   modport master (
      input  ex_valid, ex_op, ex_result, ex_addr, ex_wdata, ex_dest,
      input  mem_gnt, mem_rvalid, mem_rdata,
      output ex_ready, mem_req, mem_we, mem_addr, mem_wdata,
      output wb_valid, wb_we, wb_dest, wb_data, mem_err
   );

   modport slave (
      output ex_valid, ex_op, ex_result, ex_addr, ex_wdata, ex_dest,
      output mem_gnt, mem_rvalid, mem_rdata,
      input  ex_ready, mem_req, mem_we, mem_addr, mem_wdata,
      input  wb_valid, wb_we, wb_dest, wb_data, mem_err
   );

endinterface

// File: rtl/mem_access_timer.sv
// 8-bit transaction watchdog: synchronous clear has priority over enable and
// tc flags the last permitted cycle (count == TIMEOUT-1).
module mem_timer #(
   parameter int unsigned TIMEOUT = 16
) (
   input  logic clk,
   input  logic reset,
   input  logic clr,
   input  logic en,
   output logic tc
);

   localparam logic [7:0] TC_VAL = 8'(TIMEOUT - 1);

   logic [7:0] count_r;

   // Watchdog counter register
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         count_r <= 8'd0;
      end else if (clr) begin
         count_r <= 8'd0;
      end else if (en) begin
         count_r <= count_r + 8'd1;
      end
   end

   assign tc = (count_r == TC_VAL);

endmodule

// File: rtl/mem_access.sv
// Memory-access stage: runs LDW/STW against the data-memory port with a
// req/gnt/rvalid handshake and emits one registered writeback record per instruction.
module mem_access
   import mem_pkg::*;
#(
   parameter int unsigned TIMEOUT = 16
) (
   input logic          clk,
   input logic          reset,
   mem_access_if.master bus
);

   mem_state_t  state_r, state_s;
   logic        req_r;
   logic        we_r;
   logic [31:0] addr_r;
   logic [31:0] wdata_r;
   logic [4:0]  dest_r;
   logic        wb_valid_r, wb_valid_s;
   logic        wb_we_r, wb_we_s;
   logic [4:0]  wb_dest_r, wb_dest_s;
   logic [31:0] wb_data_r, wb_data_s;
   logic        err_r, err_s;
   logic        latch_s, tmr_clr_s, tmr_en_s, tmr_tc_s;
   logic        accept_s, is_mem_s;

   assign accept_s = bus.ex_valid && (state_r == IDLE);
   assign is_mem_s = (bus.ex_op == OP_LDW) || (bus.ex_op == OP_STW);

   mem_timer #(.TIMEOUT(TIMEOUT)) u_timer (
      .clk   (clk),
      .reset (reset),
      .clr   (tmr_clr_s),
      .en    (tmr_en_s),
      .tc    (tmr_tc_s)
   );

   // Next-state, timer control and next writeback record
   always_comb begin
      state_s    = state_r;
      latch_s    = 1'b0;
      tmr_clr_s  = 1'b0;
      tmr_en_s   = 1'b0;
      wb_valid_s = 1'b0;
      wb_we_s    = 1'b0;
      wb_dest_s  = wb_dest_r;
      wb_data_s  = wb_data_r;
      err_s      = 1'b0;
      case (state_r)
         IDLE: begin
            if (accept_s && is_mem_s) begin
               latch_s   = 1'b1;
               tmr_clr_s = 1'b1;
               state_s   = REQ;
               err_s     = (bus.ex_addr[1:0] != 2'b00);
            end else if (accept_s && (is_alu_op(bus.ex_op) || is_branch_op(bus.ex_op))) begin
               wb_valid_s = 1'b1;
               wb_we_s    = is_alu_op(bus.ex_op);
               wb_dest_s  = bus.ex_dest;
               wb_data_s  = bus.ex_result;
            end else begin
               state_s = IDLE;
            end
         end
         REQ: begin
            if (bus.mem_gnt) begin
               tmr_clr_s = 1'b1;
               if (we_r) begin
                  state_s    = IDLE;
                  wb_valid_s = 1'b1;
                  wb_dest_s  = dest_r;
               end else begin
                  state_s = WAIT;
               end
            end else if (tmr_tc_s) begin
               state_s    = IDLE;
               wb_valid_s = 1'b1;
               wb_dest_s  = dest_r;
               err_s      = 1'b1;
            end else begin
               tmr_en_s = 1'b1;
            end
         end
         WAIT: begin
            // A late gnt here is meaningless; only rvalid completes the load.
            if (bus.mem_rvalid) begin
               state_s    = IDLE;
               wb_valid_s = 1'b1;
               wb_we_s    = 1'b1;
               wb_dest_s  = dest_r;
               wb_data_s  = bus.mem_rdata;
            end else if (tmr_tc_s) begin
               state_s    = IDLE;
               wb_valid_s = 1'b1;
               wb_dest_s  = dest_r;
               err_s      = 1'b1;
            end else begin
               tmr_en_s = 1'b1;
            end
         end
         default: begin
            state_s = IDLE;
         end
      endcase
   end

   // State, latched transaction and registered output stage
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_r    <= IDLE;
         req_r      <= 1'b0;
         we_r       <= 1'b0;
         addr_r     <= 32'h0000_0000;
         wdata_r    <= 32'h0000_0000;
         dest_r     <= 5'd0;
         wb_valid_r <= 1'b0;
         wb_we_r    <= 1'b0;
         wb_dest_r  <= 5'd0;
         wb_data_r  <= 32'h0000_0000;
         err_r      <= 1'b0;
      end else begin
         state_r    <= state_s;
         req_r      <= (state_s == REQ);
         wb_valid_r <= wb_valid_s;
         wb_we_r    <= wb_we_s;
         wb_dest_r  <= wb_dest_s;
         wb_data_r  <= wb_data_s;
         err_r      <= err_s;
         if (latch_s) begin
            we_r    <= (bus.ex_op == OP_STW);
            addr_r  <= {bus.ex_addr[31:2], 2'b00};
            wdata_r <= bus.ex_wdata;
            dest_r  <= bus.ex_dest;
         end
      end
   end

   assign bus.ex_ready  = (state_r == IDLE);
   assign bus.mem_req   = req_r;
   assign bus.mem_we    = we_r;
   assign bus.mem_addr  = addr_r;
   assign bus.mem_wdata = wdata_r;
   assign bus.wb_valid  = wb_valid_r;
   assign bus.wb_we     = wb_we_r;
   assign bus.wb_dest   = wb_dest_r;
   assign bus.wb_data   = wb_data_r;
   assign bus.mem_err   = err_r;

endmodule

// File: tb/tb_mem_access.sv
// Directed bench for mem_access: a vector table for ALU/branch/no-op writeback
// plus hand-written load, store, timeout, misalignment and reset sequences.
module tb_mem_access;

   logic clk;
   logic reset;
   int   n_checks;
   int   n_pass;

   mem_access_if bus_if ();

   mem_access #(.TIMEOUT(16)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus_if)
   );

   typedef struct {
      logic [5:0]  op;
      logic [31:0] result;
      logic [4:0]  dest;
      logic        exp_valid;
      logic        exp_we;
   } alu_vec_t;

   alu_vec_t vecs [6];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic issue(input logic [5:0] op, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [4:0] dest);
      bus_if.ex_op    = op;
      bus_if.ex_addr  = addr;
      bus_if.ex_wdata = wdata;
      bus_if.ex_dest  = dest;
      bus_if.ex_valid = 1'b1;
      step();
      bus_if.ex_valid = 1'b0;
   endtask

   initial begin
      int n;
      int low;
      n_checks = 0;
      n_pass   = 0;

      vecs[0] = '{6'h00, 32'h0000_0007, 5'd5,  1'b1, 1'b1};
      vecs[1] = '{6'h0B, 32'hFFFF_FFFF, 5'd31, 1'b1, 1'b1};
      vecs[2] = '{6'h0E, 32'h0000_1234, 5'd3,  1'b1, 1'b0};
      vecs[3] = '{6'h10, 32'h0000_A5A5, 5'd7,  1'b1, 1'b0};
      vecs[4] = '{6'h3F, 32'h0000_0099, 5'd9,  1'b0, 1'b0};
      vecs[5] = '{6'h05, 32'h8000_0001, 5'd1,  1'b1, 1'b1};

      reset             = 1'b0;
      bus_if.ex_valid   = 1'b0;
      bus_if.ex_op      = 6'h00;
      bus_if.ex_result  = 32'h0;
      bus_if.ex_addr    = 32'h0;
      bus_if.ex_wdata   = 32'h0;
      bus_if.ex_dest    = 5'd0;
      bus_if.mem_gnt    = 1'b0;
      bus_if.mem_rvalid = 1'b0;
      bus_if.mem_rdata  = 32'h0;

      // Reset state
      step();
      step();
      check("rst ex_ready",  32'(bus_if.ex_ready),  32'd1);
      check("rst mem_req",   32'(bus_if.mem_req),   32'd0);
      check("rst mem_we",    32'(bus_if.mem_we),    32'd0);
      check("rst wb_valid",  32'(bus_if.wb_valid),  32'd0);
      check("rst mem_err",   32'(bus_if.mem_err),   32'd0);
      check("rst mem_addr",  bus_if.mem_addr,       32'h0);
      check("rst wb_data",   bus_if.wb_data,        32'h0);
      check("rst wb_dest",   32'(bus_if.wb_dest),   32'd0);
      reset = 1'b1;
      step();

      // Back-to-back ALU / branch / no-op vectors
      for (int i = 0; i < 6; i++) begin
         bus_if.ex_op     = vecs[i].op;
         bus_if.ex_result = vecs[i].result;
         bus_if.ex_dest   = vecs[i].dest;
         bus_if.ex_addr   = 32'h0000_0000;
         bus_if.ex_valid  = 1'b1;
         check($sformatf("vec%0d ex_ready", i), 32'(bus_if.ex_ready), 32'd1);
         step();
         check($sformatf("vec%0d wb_valid", i), 32'(bus_if.wb_valid), 32'(vecs[i].exp_valid));
         check($sformatf("vec%0d wb_we", i),    32'(bus_if.wb_we),    32'(vecs[i].exp_we));
         check($sformatf("vec%0d mem_req", i),  32'(bus_if.mem_req),  32'd0);
         if (vecs[i].exp_valid) begin
            check($sformatf("vec%0d wb_dest", i), 32'(bus_if.wb_dest), 32'(vecs[i].dest));
            check($sformatf("vec%0d wb_data", i), bus_if.wb_data,      vecs[i].result);
         end
      end
      bus_if.ex_valid = 1'b0;
      step();

      // LDW 0x100: gnt immediately, rvalid after three idle WAIT cycles
      issue(6'h0C, 32'h0000_0100, 32'h0, 5'd2);
      check("ldw mem_req",  32'(bus_if.mem_req), 32'd1);
      check("ldw mem_addr", bus_if.mem_addr,     32'h0000_0100);
      check("ldw mem_we",   32'(bus_if.mem_we),  32'd0);
      low = 0;
      for (int c = 1; c <= 5; c++) begin
         if (!bus_if.ex_ready) low++;
         bus_if.mem_gnt    = (c == 1);
         bus_if.mem_rvalid = (c == 5);
         bus_if.mem_rdata  = (c == 5) ? 32'hDEAD_BEEF : 32'h0;
         if (c == 3) begin
            check("ldw wait mem_req",  32'(bus_if.mem_req),  32'd0);
            check("ldw wait wb_valid", 32'(bus_if.wb_valid), 32'd0);
         end
         step();
      end
      bus_if.mem_gnt    = 1'b0;
      bus_if.mem_rvalid = 1'b0;
      check("ldw ready low cycles", 32'(low),             32'd5);
      check("ldw wb_valid",         32'(bus_if.wb_valid), 32'd1);
      check("ldw wb_we",            32'(bus_if.wb_we),    32'd1);
      check("ldw wb_dest",          32'(bus_if.wb_dest),  32'd2);
      check("ldw wb_data",          bus_if.wb_data,       32'hDEAD_BEEF);
      check("ldw ex_ready back",    32'(bus_if.ex_ready), 32'd1);

      // STW 0x204 with gnt withheld two cycles
      issue(6'h0D, 32'h0000_0204, 32'h0000_0055, 5'd4);
      for (int c = 1; c <= 3; c++) begin
         check($sformatf("stw c%0d mem_req", c),   32'(bus_if.mem_req), 32'd1);
         check($sformatf("stw c%0d mem_we", c),    32'(bus_if.mem_we),  32'd1);
         check($sformatf("stw c%0d mem_addr", c),  bus_if.mem_addr,     32'h0000_0204);
         check($sformatf("stw c%0d mem_wdata", c), bus_if.mem_wdata,    32'h0000_0055);
         bus_if.mem_gnt = (c == 3);
         step();
      end
      bus_if.mem_gnt = 1'b0;
      check("stw wb_valid", 32'(bus_if.wb_valid), 32'd1);
      check("stw wb_we",    32'(bus_if.wb_we),    32'd0);
      check("stw mem_req",  32'(bus_if.mem_req),  32'd0);
      check("stw ex_ready", 32'(bus_if.ex_ready), 32'd1);

      // LDW with no gnt: watchdog abort after 16 REQ cycles
      issue(6'h0C, 32'h0000_0300, 32'h0, 5'd6);
      n = 0;
      for (int c = 0; c < 40; c++) begin
         if (!bus_if.mem_req) break;
         n++;
         step();
      end
      check("tmo req cycles", 32'(n),               32'd16);
      check("tmo wb_valid",   32'(bus_if.wb_valid), 32'd1);
      check("tmo wb_we",      32'(bus_if.wb_we),    32'd0);
      check("tmo mem_err",    32'(bus_if.mem_err),  32'd1);
      check("tmo ex_ready",   32'(bus_if.ex_ready), 32'd1);
      step();
      check("tmo err pulse",  32'(bus_if.mem_err),  32'd0);
      check("tmo wb pulse",   32'(bus_if.wb_valid), 32'd0);

      // Misaligned LDW 0x103 against zero-wait memory
      issue(6'h0C, 32'h0000_0103, 32'h0, 5'd8);
      check("mis mem_addr", bus_if.mem_addr,     32'h0000_0100);
      check("mis mem_err",  32'(bus_if.mem_err), 32'd1);
      check("mis mem_req",  32'(bus_if.mem_req), 32'd1);
      bus_if.mem_gnt = 1'b1;
      step();
      bus_if.mem_gnt    = 1'b0;
      bus_if.mem_rvalid = 1'b1;
      bus_if.mem_rdata  = 32'h0BAD_F00D;
      check("mis err cleared", 32'(bus_if.mem_err),  32'd0);
      check("mis ready low",   32'(bus_if.ex_ready), 32'd0);
      step();
      bus_if.mem_rvalid = 1'b0;
      check("mis wb_valid", 32'(bus_if.wb_valid), 32'd1);
      check("mis wb_data",  bus_if.wb_data,       32'h0BAD_F00D);
      check("mis ex_ready", 32'(bus_if.ex_ready), 32'd1);

      // Reset while in REQ drops mem_req without waiting for a clock
      issue(6'h0D, 32'h0000_0500, 32'h0000_0011, 5'd10);
      check("rreq mem_req before", 32'(bus_if.mem_req), 32'd1);
      #2 reset = 1'b0;
      #1 check("rreq mem_req async", 32'(bus_if.mem_req), 32'd0);
      @(negedge clk);
      reset = 1'b1;
      step();

      // Reset while in WAIT; a late rvalid must not produce a writeback
      issue(6'h0C, 32'h0000_0400, 32'h0, 5'd12);
      bus_if.mem_gnt = 1'b1;
      step();
      bus_if.mem_gnt = 1'b0;
      check("rwait in wait", 32'(bus_if.ex_ready), 32'd0);
      #2 reset = 1'b0;
      #1;
      check("rwait mem_req",  32'(bus_if.mem_req),  32'd0);
      check("rwait wb_valid", 32'(bus_if.wb_valid), 32'd0);
      check("rwait ex_ready", 32'(bus_if.ex_ready), 32'd1);
      @(negedge clk);
      reset             = 1'b1;
      bus_if.mem_rvalid = 1'b1;
      bus_if.mem_rdata  = 32'h1234_5678;
      step();
      bus_if.mem_rvalid = 1'b0;
      check("rwait late rvalid", 32'(bus_if.wb_valid), 32'd0);
      step();
      check("rwait still quiet", 32'(bus_if.wb_valid), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
